mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 if_req_i  input  1  instruction-fetch request; held high until if_done_o.
REQ-004 if_addr_i  input  32  fetch byte address.
REQ-005 if_done_o  output  1  one-cycle pulse; if_data_o valid in the same cycle.
REQ-006 if_data_o  output  32  fetched instruction word, little-endian.
REQ-007 mem_req_i  input  1  load/store request from MEM stage; held high until mem_done_o.
REQ-008 mem_we_i  input  1  1 = store, 0 = load.
REQ-009 mem_sel_i  input  2  access width: 00 none, 01 byte, 10 half, 11 word.
REQ-010 mem_signed_i  input  1  load sign-extend (1) or zero-extend (0).
REQ-011 mem_addr_i  input  32  data byte address.
REQ-012 mem_wdata_i  input  32  store data; low bytes used per mem_sel_i.
REQ-013 mem_done_o  output  1  one-cycle pulse; mem_rdata_o valid in the same cycle.
REQ-014 mem_rdata_o  output  32  extended load result.
REQ-015 ram_addr_o  output  32  byte address to single-port byte-wide RAM.
REQ-016 ram_we_o  output  1  RAM write enable.
REQ-017 ram_dout_o  output  8  RAM write byte.
REQ-018 ram_din_i  input  8  RAM read byte; returns the byte for the address presented one cycle earlier.
REQ-019 busy_o  output  1  high in every non-IDLE state.

Function
REQ-020 FSM states SHALL be IDLE, BUSY, DONE; all outputs SHALL be registered.
REQ-021 In IDLE, requests are sampled; a grant latches address, width n (IF always 4), direction, write data and signedness, and enters BUSY with counter cnt=0.
REQ-022 Fixed priority: mem_req_i wins over if_req_i when both are high in the same IDLE cycle.
REQ-023 Read: in BUSY cycle with cnt=k (k<n), ram_addr_o=base+k and ram_we_o=0; ram_din_i in cycle cnt=k+1 is stored as byte k; BUSY lasts n+1 cycles.
REQ-024 Write: in BUSY cycle cnt=k, ram_addr_o=base+k, ram_we_o=1, ram_dout_o=wdata[8k+7:8k]; BUSY lasts n cycles.
REQ-025 Address increment SHALL wrap modulo 2^32 (0xFFFFFFFF+1 = 0x00000000).
REQ-026 DONE lasts exactly one cycle and pulses the granted requester's done; ram_we_o=0 in DONE; next state IDLE.
REQ-027 Latency from request-sampling cycle to done cycle: read n+2, write n+1 (word read 6, byte write 2).
REQ-028 Loads: byte/half SHALL be sign- or zero-extended per mem_signed_i; word loaded unmodified; if_data_o never extended.
REQ-029 mem_sel_i=00: no RAM cycle; BUSY skipped; DONE next cycle, mem_rdata_o=0.
REQ-030 Request inputs are ignored outside IDLE; deassertion mid-access does not abort; done still pulses.
REQ-031 Non-granted requester's done and data outputs SHALL hold their previous values, done=0.
REQ-032 A requester SHALL drop its request in the cycle after its done; a request still high in IDLE is treated as new.

Reset
REQ-033 With rst high at a clock edge: state IDLE, cnt=0, ram_addr_o=0, ram_we_o=0, ram_dout_o=0, if_done_o=0, mem_done_o=0, if_data_o=0, mem_rdata_o=0, busy_o=0.
REQ-034 rst mid-access aborts immediately: no done pulse; ram_we_o=0 from the next cycle; partial writes already issued remain in RAM.

Configuration
REQ-035 Macro MEM_CTRL_RR_ARB_EN: when defined, simultaneous IDLE requests are granted round-robin (grant the requester not granted last; first after reset MEM); when undefined, fixed MEM priority per REQ-022.

Verification
REQ-036 RAM[0x100..0x103]=78 56 34 12, IF read 0x100 -> if_done_o in cycle 6, if_data_o=0x12345678, ram_addr_o 0x100..0x103 in cycles 1-4.
REQ-037 MEM store word 0xDEADBEEF @0x200 -> we=1 in cycles 1-4, bytes EF BE AD DE, mem_done_o in cycle 5.
REQ-038 RAM[0x10]=0x80, load byte signed -> 0xFFFFFF80; unsigned -> 0x00000080; half 0x8001 signed -> 0xFFFF8001.
REQ-039 IF and MEM requests both high in the same cycle -> MEM served first, IF done follows; with MEM_CTRL_RR_ARB_EN, back-to-back contention alternates grants.
REQ-040 Half load at 0xFFFFFFFF -> addresses 0xFFFFFFFF then 0x00000000.
REQ-041 rst asserted in BUSY cycle 2 of a word store -> no mem_done_o, ram_we_o=0 next cycle, busy_o=0.

Source files
------------

// File: rtl/mem_ctrl.sv
// Multi-cycle fetch/load/store sequencer over a single-port byte-wide RAM (IDLE/BUSY/DONE).
// Define MEM_CTRL_RR_ARB_EN for round-robin arbitration; otherwise the MEM requester has fixed priority.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_done_o,
  output logic [31:0] if_data_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [1:0]  mem_sel_i,
  input  logic        mem_signed_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic        mem_done_o,
  output logic [31:0] mem_rdata_o,
  output logic [31:0] ram_addr_o,
  output logic        ram_we_o,
  output logic [7:0]  ram_dout_o,
  input  logic [7:0]  ram_din_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d, n_q, n_d;
  logic        mem_q, mem_d, we_q, we_d, sgn_q, sgn_d;
  logic [1:0]  sel_q, sel_d, bidx, didx;
  logic [31:0] wdata_q, wdata_d, rbuf_q, rbuf_d;
  logic        if_done_d, mem_done_d, ram_we_d, busy_d;
  logic [31:0] if_data_d, mem_rdata_d, ram_addr_d;
  logic [7:0]  ram_dout_d;
  logic        grant_mem, grant_if;
`ifdef MEM_CTRL_RR_ARB_EN
  logic        last_mem_q, last_mem_d;
`endif

  function automatic logic [2:0] width_bytes(input logic [1:0] sel);
    case (sel)
      2'b01:   width_bytes = 3'd1;
      2'b10:   width_bytes = 3'd2;
      2'b11:   width_bytes = 3'd4;
      default: width_bytes = 3'd0;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] raw, input logic [1:0] sel,
                                              input logic sgn);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    b = raw[7:0];
    h = raw[15:0];
    r = raw;
    case (sel)
      2'b01:   r = sgn ? 32'(b) : {24'd0, raw[7:0]};
      2'b10:   r = sgn ? 32'(h) : {16'd0, raw[15:0]};
      default: r = raw;
    endcase
    load_extend = r;
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    mem_d       = mem_q;
    we_d        = we_q;
    sgn_d       = sgn_q;
    sel_d       = sel_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    ram_we_d    = 1'b0;
    if_data_d   = if_data_o;
    mem_rdata_d = mem_rdata_o;
    ram_addr_d  = ram_addr_o;
    ram_dout_d  = ram_dout_o;
    bidx        = cnt_q[1:0] - 2'd1;
    didx        = cnt_q[1:0] + 2'd1;
`ifdef MEM_CTRL_RR_ARB_EN
    last_mem_d  = last_mem_q;
    grant_mem   = mem_req_i && !(if_req_i && last_mem_q);
`else
    grant_mem   = mem_req_i;
`endif
    grant_if    = if_req_i && !grant_mem;

    case (state_q)
      IDLE: begin
        if (grant_mem) begin
          mem_d   = 1'b1;
          we_d    = mem_we_i;
          sel_d   = mem_sel_i;
          sgn_d   = mem_signed_i;
          wdata_d = mem_wdata_i;
          n_d     = width_bytes(mem_sel_i);
          cnt_d   = 3'd0;
          rbuf_d  = 32'd0;
`ifdef MEM_CTRL_RR_ARB_EN
          last_mem_d = 1'b1;
`endif
          if (mem_sel_i == 2'b00) begin
            // Zero-width access completes without touching the RAM
            state_d     = DONE;
            mem_done_d  = 1'b1;
            mem_rdata_d = 32'd0;
          end else begin
            state_d    = BUSY;
            ram_addr_d = mem_addr_i;
            ram_we_d   = mem_we_i;
            ram_dout_d = mem_wdata_i[7:0];
          end
        end else if (grant_if) begin
          mem_d      = 1'b0;
          we_d       = 1'b0;
          sel_d      = 2'b11;
          sgn_d      = 1'b0;
          n_d        = 3'd4;
          cnt_d      = 3'd0;
          rbuf_d     = 32'd0;
          state_d    = BUSY;
          ram_addr_d = if_addr_i;
`ifdef MEM_CTRL_RR_ARB_EN
          last_mem_d = 1'b0;
`endif
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 3'd1;
        if (we_q) begin
          if (cnt_q + 3'd1 == n_q) begin
            state_d    = DONE;
            mem_done_d = 1'b1;
          end else begin
            ram_addr_d = ram_addr_o + 32'd1;
            ram_we_d   = 1'b1;
            ram_dout_d = wdata_q[{didx, 3'b000} +: 8];
          end
        end else begin
          // RAM read data lags the address by one cycle, so byte k lands at cnt=k+1
          if (cnt_q != 3'd0)
            rbuf_d[{bidx, 3'b000} +: 8] = ram_din_i;
          if (cnt_q == n_q) begin
            state_d = DONE;
            if (mem_q) begin
              mem_done_d  = 1'b1;
              mem_rdata_d = load_extend(rbuf_d, sel_q, sgn_q);
            end else begin
              if_done_d = 1'b1;
              if_data_d = rbuf_d;
            end
          end else if (cnt_q + 3'd1 < n_q) begin
            ram_addr_d = ram_addr_o + 32'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      if_done_o   <= 1'b0;
      if_data_o   <= 32'd0;
      mem_done_o  <= 1'b0;
      mem_rdata_o <= 32'd0;
      ram_addr_o  <= 32'd0;
      ram_we_o    <= 1'b0;
      ram_dout_o  <= 8'd0;
      busy_o      <= 1'b0;
`ifdef MEM_CTRL_RR_ARB_EN
      last_mem_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      if_done_o   <= if_done_d;
      if_data_o   <= if_data_d;
      mem_done_o  <= mem_done_d;
      mem_rdata_o <= mem_rdata_d;
      ram_addr_o  <= ram_addr_d;
      ram_we_o    <= ram_we_d;
      ram_dout_o  <= ram_dout_d;
      busy_o      <= busy_d;
`ifdef MEM_CTRL_RR_ARB_EN
      last_mem_q  <= last_mem_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    n_q     <= n_d;
    mem_q   <= mem_d;
    we_q    <= we_d;
    sgn_q   <= sgn_d;
    sel_q   <= sel_d;
    wdata_q <= wdata_d;
    rbuf_q  <= rbuf_d;
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: transaction-level model schedules expected outputs per cycle, compared every cycle.
module tb_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_done_o;
  logic [31:0] if_data_o;
  logic        mem_req_i, mem_we_i, mem_signed_i;
  logic [1:0]  mem_sel_i;
  logic [31:0] mem_addr_i, mem_wdata_i;
  logic        mem_done_o;
  logic [31:0] mem_rdata_o;
  logic [31:0] ram_addr_o;
  logic        ram_we_o;
  logic [7:0]  ram_dout_o;
  logic [7:0]  ram_din_i;
  logic        busy_o;

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_done_o(if_done_o), .if_data_o(if_data_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i), .mem_signed_i(mem_signed_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .mem_done_o(mem_done_o),
    .mem_rdata_o(mem_rdata_o), .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o),
    .ram_dout_o(ram_dout_o), .ram_din_i(ram_din_i), .busy_o(busy_o)
  );

  typedef struct {
    bit          is_mem;
    bit          we;
    logic [1:0]  sel;
    bit          sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit chk_on = 1'b0;

  // Byte RAM seen by the DUT, one-cycle read latency
  bit [7:0]    ram [0:4095];
  logic        pl_we = 1'b0;
  logic [31:0] pl_addr = 32'd0;
  logic [7:0]  pl_data = 8'd0;

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    ram_din_i <= ram[ram_addr_o[11:0]];
    if (pl_we)         ram[pl_addr[11:0]]    <= pl_data;
    else if (ram_we_o) ram[ram_addr_o[11:0]] <= ram_dout_o;
  end

  // Model state
  logic [7:0]  ref_mem [logic [31:0]];
  bit          e_busy[int], e_we[int], e_ifd[int], e_memd[int], e_rst[int];
  logic [31:0] e_addr[int], e_idata[int], e_mdata[int];
  logic [7:0]  e_dout[int];
  logic [31:0] hold_if = 32'd0, hold_mem = 32'd0;
  bit          m_last_mem = 1'b0;
  int          last_if_cyc = -1, last_mem_cyc = -1;
  logic [31:0] last_if_data = 32'd0, last_mem_data = 32'd0;
  logic [31:0] addr_log[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic txn_t mk(input bit is_mem, input bit we, input logic [1:0] sel,
                              input bit sgn, input logic [31:0] addr, input logic [31:0] wdata);
    txn_t t;
    t.is_mem = is_mem; t.we = we; t.sel = sel; t.sgn = sgn; t.addr = addr; t.wdata = wdata;
    return t;
  endfunction

  always @(negedge clk) begin : cmp
    logic [31:0] nif, nmem;
    if (chk_on) begin
      nif  = hold_if;
      nmem = hold_mem;
      if (e_rst.exists(cyc)) begin nif = 32'd0; nmem = 32'd0; end
      if (e_idata.exists(cyc)) nif = e_idata[cyc];
      if (e_mdata.exists(cyc)) nmem = e_mdata[cyc];
      chk("busy", {31'd0, busy_o}, e_busy.exists(cyc));
      chk("ram_we", {31'd0, ram_we_o}, e_we.exists(cyc));
      if (e_addr.exists(cyc)) begin
        chk("ram_addr", ram_addr_o, e_addr[cyc]);
        addr_log.push_back(ram_addr_o);
      end
      if (e_dout.exists(cyc)) chk("ram_dout", {24'd0, ram_dout_o}, {24'd0, e_dout[cyc]});
      chk("if_done", {31'd0, if_done_o}, e_ifd.exists(cyc));
      chk("mem_done", {31'd0, mem_done_o}, e_memd.exists(cyc));
      chk("if_data", if_data_o, nif);
      chk("mem_rdata", mem_rdata_o, nmem);
      hold_if  <= nif;
      hold_mem <= nmem;
      if (if_done_o)  begin last_if_cyc  <= cyc; last_if_data  <= if_data_o;   end
      if (mem_done_o) begin last_mem_cyc <= cyc; last_mem_data <= mem_rdata_o; end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    ref_mem[a] = d;
    tick(1);
    pl_we = 1'b0;
  endtask

  task automatic drive(input txn_t t, input bit on);
    if (t.is_mem) begin
      mem_req_i = on;
      if (on) begin
        mem_we_i = t.we; mem_sel_i = t.sel; mem_signed_i = t.sgn;
        mem_addr_i = t.addr; mem_wdata_i = t.wdata;
      end
    end else begin
      if_req_i = on;
      if (on) if_addr_i = t.addr;
    end
  endtask

  // Transaction granted in sampling cycle c: schedule what every later cycle must show
  task automatic model(input txn_t t, input int c, output int lat);
    int n;
    logic [31:0] val;
    n = !t.is_mem ? 4 : (t.sel == 2'b01) ? 1 : (t.sel == 2'b10) ? 2 : (t.sel == 2'b11) ? 4 : 0;
    m_last_mem = t.is_mem;
    if (n == 0) begin
      lat = 1;
      e_busy[c+1] = 1'b1; e_memd[c+1] = 1'b1; e_mdata[c+1] = 32'd0;
    end else if (t.we) begin
      lat = n + 1;
      for (int k = 0; k < n; k++) begin
        e_busy[c+1+k] = 1'b1;
        e_we[c+1+k]   = 1'b1;
        e_addr[c+1+k] = t.addr + k;
        e_dout[c+1+k] = 8'(t.wdata >> (8*k));
        ref_mem[t.addr + k] = 8'(t.wdata >> (8*k));
      end
      e_busy[c+lat] = 1'b1;
      e_memd[c+lat] = 1'b1;
    end else begin
      lat = n + 2;
      val = 32'd0;
      for (int k = 0; k < n; k++) begin
        e_addr[c+1+k] = t.addr + k;
        val = val | (32'(ref_rd(t.addr + k)) << (8*k));
      end
      for (int k = 1; k <= lat; k++) e_busy[c+k] = 1'b1;
      if (t.is_mem && t.sgn && n < 4 && val[8*n-1]) val = val - (32'd1 << (8*n));
      if (t.is_mem) begin e_memd[c+lat] = 1'b1; e_mdata[c+lat] = val; end
      else          begin e_ifd[c+lat]  = 1'b1; e_idata[c+lat] = val; end
    end
  endtask

  task automatic do_txn(input txn_t t, output int c);
    int lat;
    c = cyc;
    drive(t, 1'b1);
    model(t, c, lat);
    tick(lat + 1);
    drive(t, 1'b0);
  endtask

  task automatic contend(input txn_t tm, input txn_t ti);
    int c, lw, ll;
    bit mem_wins;
`ifdef MEM_CTRL_RR_ARB_EN
    mem_wins = !m_last_mem;
`else
    mem_wins = 1'b1;
`endif
    c = cyc;
    drive(tm, 1'b1);
    drive(ti, 1'b1);
    if (mem_wins) begin
      model(tm, c, lw); model(ti, c + lw + 1, ll);
      tick(lw + 1); drive(tm, 1'b0);
      tick(ll + 1); drive(ti, 1'b0);
    end else begin
      model(ti, c, lw); model(tm, c + lw + 1, ll);
      tick(lw + 1); drive(ti, 1'b0);
      tick(ll + 1); drive(tm, 1'b0);
    end
  endtask

  initial begin : main
    int c, b, lat;
    txn_t t, t2;
    rst = 1'b1;
    if_req_i = 1'b0; if_addr_i = 32'd0;
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_sel_i = 2'b00; mem_signed_i = 1'b0;
    mem_addr_i = 32'd0; mem_wdata_i = 32'd0;

    preload(32'h100, 8'h78); preload(32'h101, 8'h56);
    preload(32'h102, 8'h34); preload(32'h103, 8'h12);
    preload(32'h10, 8'h80);
    preload(32'h20, 8'h01);  preload(32'h21, 8'h80);
    preload(32'hFFFFFFFF, 8'h34); preload(32'h0, 8'h92);
    tick(1);

    chk("rst_busy", {31'd0, busy_o}, 0);
    chk("rst_we", {31'd0, ram_we_o}, 0);
    chk("rst_addr", ram_addr_o, 0);
    chk("rst_dout", {24'd0, ram_dout_o}, 0);
    chk("rst_if_done", {31'd0, if_done_o}, 0);
    chk("rst_mem_done", {31'd0, mem_done_o}, 0);
    chk("rst_if_data", if_data_o, 0);
    chk("rst_mem_rdata", mem_rdata_o, 0);
    rst = 1'b0;
    chk_on = 1'b1;
    tick(1);

    // Contention straight after reset: MEM goes first in either arbitration mode
    contend(mk(1, 0, 2'b01, 1, 32'h10, 0), mk(0, 0, 2'b11, 0, 32'h100, 0));
    chk("arb1_mem_first", {31'd0, last_mem_cyc < last_if_cyc}, 1);
    chk("arb1_mem_data", last_mem_data, 32'hFFFFFF80);

    b = addr_log.size();
    do_txn(mk(0, 0, 2'b11, 0, 32'h100, 0), c);
    chk("if_lat", last_if_cyc - c, 6);
    chk("if_word", last_if_data, 32'h12345678);
    chk("if_addr0", addr_log[b], 32'h100);
    chk("if_addr3", addr_log[b+3], 32'h103);

    do_txn(mk(1, 1, 2'b11, 0, 32'h200, 32'hDEADBEEF), c);
    chk("st_lat", last_mem_cyc - c, 5);
    chk("st_bytes", {ram[12'h203], ram[12'h202], ram[12'h201], ram[12'h200]}, 32'hDEADBEEF);

    do_txn(mk(1, 0, 2'b11, 1, 32'h200, 0), c);
    chk("ld_word", last_mem_data, 32'hDEADBEEF);
    do_txn(mk(1, 0, 2'b01, 1, 32'h10, 0), c);
    chk("ld_byte_s", last_mem_data, 32'hFFFFFF80);
    do_txn(mk(1, 0, 2'b01, 0, 32'h10, 0), c);
    chk("ld_byte_u", last_mem_data, 32'h00000080);
    do_txn(mk(1, 0, 2'b10, 1, 32'h20, 0), c);
    chk("ld_half_s", last_mem_data, 32'hFFFF8001);

    b = addr_log.size();
    do_txn(mk(1, 0, 2'b10, 0, 32'hFFFFFFFF, 0), c);
    chk("wrap_a0", addr_log[b], 32'hFFFFFFFF);
    chk("wrap_a1", addr_log[b+1], 32'h00000000);
    chk("wrap_data", last_mem_data, 32'h00009234);

    do_txn(mk(1, 0, 2'b00, 1, 32'h10, 0), c);
    chk("sel0_lat", last_mem_cyc - c, 1);
    chk("sel0_data", last_mem_data, 32'd0);

    do_txn(mk(1, 1, 2'b01, 0, 32'h300, 32'hFFFFFFA5), c);
    chk("stb_lat", last_mem_cyc - c, 2);
    do_txn(mk(1, 1, 2'b10, 0, 32'h301, 32'h1234BEEF), c);
    do_txn(mk(1, 0, 2'b11, 0, 32'h300, 0), c);
    chk("mixed_word", last_mem_data, 32'h00BEEFA5);

    // Contention after a MEM grant: fixed priority keeps MEM, round-robin switches to IF
    contend(mk(1, 0, 2'b10, 1, 32'h20, 0), mk(0, 0, 2'b11, 0, 32'h100, 0));
`ifdef MEM_CTRL_RR_ARB_EN
    chk("arb2_if_first", {31'd0, last_if_cyc < last_mem_cyc}, 1);
`else
    chk("arb2_mem_first", {31'd0, last_mem_cyc < last_if_cyc}, 1);
`endif

    // IF drops its request mid-access; MEM request raised while busy waits for IDLE
    t = mk(0, 0, 2'b11, 0, 32'h200, 0);
    t2 = mk(1, 0, 2'b10, 0, 32'h20, 0);
    c = cyc;
    drive(t, 1'b1);
    model(t, c, lat);
    tick(2);
    drive(t, 1'b0);
    drive(t2, 1'b1);
    tick(lat - 1);
    model(t2, c + lat + 1, lat);
    tick(lat + 1);
    drive(t2, 1'b0);
    chk("abort_if_data", last_if_data, 32'hDEADBEEF);
    chk("late_mem_data", last_mem_data, 32'h00008001);

    // Reset during the second BUSY cycle of a word store
    t = mk(1, 1, 2'b11, 0, 32'h400, 32'h11223344);
    c = cyc;
    drive(t, 1'b1);
    for (int k = 0; k < 2; k++) begin
      e_busy[c+1+k] = 1'b1;
      e_we[c+1+k]   = 1'b1;
      e_addr[c+1+k] = 32'h400 + k;
      e_dout[c+1+k] = 8'(t.wdata >> (8*k));
      ref_mem[32'h400 + k] = 8'(t.wdata >> (8*k));
    end
    e_rst[c+3] = 1'b1;
    tick(2);
    rst = 1'b1;
    drive(t, 1'b0);
    tick(1);
    rst = 1'b0;
    m_last_mem = 1'b0;
    chk("rst_mid_busy", {31'd0, busy_o}, 0);
    chk("rst_mid_we", {31'd0, ram_we_o}, 0);
    chk("rst_mid_done", {31'd0, mem_done_o}, 0);
    tick(3);
    chk("rst_partial", {ram[12'h403], ram[12'h402], ram[12'h401], ram[12'h400]}, 32'h00003344);

    contend(mk(1, 0, 2'b01, 0, 32'h10, 0), mk(0, 0, 2'b11, 0, 32'h300, 0));
    chk("arb3_mem_first", {31'd0, last_mem_cyc < last_if_cyc}, 1);
    do_txn(mk(1, 0, 2'b11, 0, 32'h400, 0), c);
    chk("rst_word", last_mem_data, 32'h00003344);

    tick(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
